// File: rtl/pc_watch_unit_if.sv
// pc_watch_unit_if: execution-trace, configuration and status bundle for the PC watchpoint unit.
`default_nettype none

interface pc_watch_unit_if #(
  parameter int NUM_WP    = 4,
  parameter int CNT_WIDTH = 16
);
  localparam int CH_W   = (NUM_WP > 1) ? $clog2(NUM_WP) : 1;
  localparam int LINE_W = 30;

  logic [31:0]               pc;
  logic                      pc_valid;
  logic                      cfg_we;
  logic [CH_W-1:0]           cfg_sel;
  logic [LINE_W-1:0]         cfg_line;
  logic [1:0]                cfg_mode;
  logic [CNT_WIDTH-1:0]      cfg_target;
  logic                      clr;
  logic                      resume;
  logic [NUM_WP-1:0]         hit_pulse;
  logic [NUM_WP*CNT_WIDTH-1:0] hit_count;
  logic                      halt;
  logic [CH_W-1:0]           halt_id;

  modport master (
    output pc, pc_valid, cfg_we, cfg_sel, cfg_line, cfg_mode, cfg_target, clr, resume,
    input  hit_pulse, hit_count, halt, halt_id
  );

  modport slave (
    input  pc, pc_valid, cfg_we, cfg_sel, cfg_line, cfg_mode, cfg_target, clr, resume,
    output hit_pulse, hit_count, halt, halt_id
  );
endinterface

`default_nettype wire

// File: rtl/pc_watch_unit.sv
// pc_watch_unit: per-channel instruction-line watchpoints with hit counters and a RUN/HALTED FSM.
// Optional macro PCWATCH_SATURATE_EN makes counters saturate at all-ones instead of wrapping.
`default_nettype none

module pc_watch_unit #(
  parameter int NUM_WP    = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic           clock,
  input  logic           nreset,
  pc_watch_unit_if.slave bus
);

  localparam int CH_W   = (NUM_WP > 1) ? $clog2(NUM_WP) : 1;
  localparam int LINE_W = 30;

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [CH_W-1:0]   halt_id_q, halt_id_d;
  logic [NUM_WP-1:0] hit_w;
  logic [NUM_WP-1:0] halting_w;
  logic [NUM_WP-1:0] hit_pulse_q;
  logic              any_halt_w;
  logic [CH_W-1:0]   halt_idx_w;
  logic              unused_pc_bits;

  assign unused_pc_bits = ^bus.pc[1:0];

  for (genvar c = 0; c < NUM_WP; c++) begin : g_ch
    logic [LINE_W-1:0]    line_q;
    logic [1:0]           mode_q;
    logic [CNT_WIDTH-1:0] target_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] inc_w;
    logic                 sel_w;

    // Out-of-range selects match no channel, so such writes are dropped.
    assign sel_w = bus.cfg_we && (bus.cfg_sel == CH_W'(c));

`ifdef PCWATCH_SATURATE_EN
    assign inc_w = (&cnt_q) ? cnt_q : cnt_q + CNT_WIDTH'(1);
`else
    assign inc_w = cnt_q + CNT_WIDTH'(1);
`endif

    assign hit_w[c] = (state_q == ST_RUN) && bus.pc_valid &&
                      (mode_q != 2'b00) && (bus.pc[31:2] == line_q);

    assign halting_w[c] = hit_w[c] &&
                          ((mode_q == 2'b10) ||
                           ((mode_q == 2'b11) && (target_q != '0) && (inc_w == target_q)));

    always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
        line_q   <= '0;
        mode_q   <= 2'b00;
        target_q <= '0;
      end else if (sel_w) begin
        line_q   <= bus.cfg_line;
        mode_q   <= bus.cfg_mode;
        target_q <= bus.cfg_target;
      end
    end

    // Clear and reconfiguration both win over a coincident increment.
    always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
        cnt_q <= '0;
      end else if (bus.clr || sel_w) begin
        cnt_q <= '0;
      end else if (hit_w[c]) begin
        cnt_q <= inc_w;
      end
    end

    assign bus.hit_count[c*CNT_WIDTH +: CNT_WIDTH] = cnt_q;
  end

  always_comb begin
    any_halt_w = 1'b0;
    halt_idx_w = '0;
    for (int i = NUM_WP - 1; i >= 0; i--) begin
      if (halting_w[i]) begin
        any_halt_w = 1'b1;
        halt_idx_w = CH_W'(i);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    halt_id_d = halt_id_q;
    case (state_q)
      ST_RUN: begin
        if (any_halt_w) begin
          state_d   = ST_HALTED;
          halt_id_d = halt_idx_w;
        end
      end
      ST_HALTED: begin
        if (bus.resume) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q     <= ST_RUN;
      halt_id_q   <= '0;
      hit_pulse_q <= '0;
    end else begin
      state_q     <= state_d;
      halt_id_q   <= halt_id_d;
      hit_pulse_q <= hit_w;
    end
  end

  assign bus.hit_pulse = hit_pulse_q;
  assign bus.halt      = (state_q == ST_HALTED);
  assign bus.halt_id   = halt_id_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_watch_unit.sv
// tb_pc_watch_unit: scoreboard bench for pc_watch_unit (NUM_WP=4, CNT_WIDTH=8) plus a 5-channel select-range check.
`default_nettype none

module tb_pc_watch_unit;

  logic clk;
  logic nreset;

  pc_watch_unit_if #(.NUM_WP(4), .CNT_WIDTH(8)) bus ();
  pc_watch_unit_if #(.NUM_WP(5), .CNT_WIDTH(8)) bus5 ();

  pc_watch_unit #(.NUM_WP(4), .CNT_WIDTH(8)) dut (
    .clock  (clk),
    .nreset (nreset),
    .bus    (bus.slave)
  );

  pc_watch_unit #(.NUM_WP(5), .CNT_WIDTH(8)) dut5 (
    .clock  (clk),
    .nreset (nreset),
    .bus    (bus5.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  pulse;
    logic [31:0] cnt;
    logic        halt;
    logic [1:0]  hid;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  string       phase = "reset";

  logic [29:0] m_line   [4];
  logic [1:0]  m_mode   [4];
  int          m_target [4];
  int          m_cnt    [4];
  logic        m_halted;
  logic [1:0]  m_hid;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s.%s: got %0h expected %0h", phase, tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 4; c++) begin
      m_line[c] = '0; m_mode[c] = 2'b00; m_target[c] = 0; m_cnt[c] = 0;
    end
    m_halted = 1'b0;
    m_hid    = 2'd0;
  endtask

  // Predict the post-edge outputs from the current inputs, queue them, then compare after the edge.
  task automatic tick();
    exp_t       e;
    logic [3:0] h;
    logic [3:0] hl;
    int         nxt [4];
    for (int c = 0; c < 4; c++) begin
      h[c] = bus.pc_valid && (m_mode[c] != 2'b00) && (bus.pc[31:2] == m_line[c]) && !m_halted;
`ifdef PCWATCH_SATURATE_EN
      nxt[c] = (m_cnt[c] == 255) ? 255 : m_cnt[c] + 1;
`else
      nxt[c] = (m_cnt[c] + 1) % 256;
`endif
      hl[c] = h[c] && ((m_mode[c] == 2'd2) ||
                       ((m_mode[c] == 2'd3) && (m_target[c] != 0) && (nxt[c] == m_target[c])));
    end
    if (!m_halted) begin
      if (hl != 4'b0) begin
        m_halted = 1'b1;
        for (int c = 3; c >= 0; c--) if (hl[c]) m_hid = 2'(c);
      end
    end else if (bus.resume) begin
      m_halted = 1'b0;
    end
    for (int c = 0; c < 4; c++) begin
      if (bus.clr) m_cnt[c] = 0;
      else if (bus.cfg_we && (int'(bus.cfg_sel) == c)) m_cnt[c] = 0;
      else if (h[c]) m_cnt[c] = nxt[c];
    end
    if (bus.cfg_we) begin
      m_line[bus.cfg_sel]   = bus.cfg_line;
      m_mode[bus.cfg_sel]   = bus.cfg_mode;
      m_target[bus.cfg_sel] = int'(bus.cfg_target);
    end
    e.pulse = h;
    e.cnt   = {m_cnt[3][7:0], m_cnt[2][7:0], m_cnt[1][7:0], m_cnt[0][7:0]};
    e.halt  = m_halted;
    e.hid   = m_hid;
    sb.push_back(e);

    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("hit_pulse", 64'(bus.hit_pulse), 64'(e.pulse));
    chk("hit_count", 64'(bus.hit_count), 64'(e.cnt));
    chk("halt",      64'(bus.halt),      64'(e.halt));
    chk("halt_id",   64'(bus.halt_id),   64'(e.hid));
    bus.pc_valid = 1'b0;
    bus.cfg_we   = 1'b0;
    bus.clr      = 1'b0;
    bus.resume   = 1'b0;
  endtask

  task automatic cfg(input logic [1:0] ch, input logic [29:0] line, input logic [1:0] mode,
                     input logic [7:0] target);
    bus.cfg_we     = 1'b1;
    bus.cfg_sel    = ch;
    bus.cfg_line   = line;
    bus.cfg_mode   = mode;
    bus.cfg_target = target;
    tick();
  endtask

  task automatic run_pc(input logic [31:0] addr);
    bus.pc       = addr;
    bus.pc_valid = 1'b1;
    tick();
  endtask

  task automatic resume_tick();
    bus.resume = 1'b1;
    tick();
  endtask

  task automatic tick5();
    @(posedge clk);
    #1;
    bus5.pc_valid = 1'b0;
    bus5.cfg_we   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    nreset = 1'b0;
    bus.pc = '0; bus.pc_valid = 1'b0; bus.cfg_we = 1'b0; bus.cfg_sel = '0;
    bus.cfg_line = '0; bus.cfg_mode = '0; bus.cfg_target = '0; bus.clr = 1'b0; bus.resume = 1'b0;
    bus5.pc = '0; bus5.pc_valid = 1'b0; bus5.cfg_we = 1'b0; bus5.cfg_sel = '0;
    bus5.cfg_line = '0; bus5.cfg_mode = '0; bus5.cfg_target = '0; bus5.clr = 1'b0; bus5.resume = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pulse", 64'(bus.hit_pulse), 64'd0);
    chk("rst_count", 64'(bus.hit_count), 64'd0);
    chk("rst_halt",  64'(bus.halt),      64'd0);
    chk("rst_hid",   64'(bus.halt_id),   64'd0);
    nreset = 1'b1;

    phase = "count";
    cfg(2'd0, 30'd1876, 2'b01, 8'd0);
    for (int i = 0; i < 3; i++) begin
      run_pc(32'd7504);
      tick();
    end

    phase = "halt_hit";
    cfg(2'd1, 30'd2375, 2'b10, 8'd0);
    run_pc(32'd9500);
    run_pc(32'd9500);
    run_pc(32'd7504);
    resume_tick();
    resume_tick();
    tick();

    phase = "dual_halt";
    cfg(2'd2, 30'd100, 2'b10, 8'd0);
    cfg(2'd3, 30'd100, 2'b10, 8'd0);
    run_pc(32'd400);
    resume_tick();

    phase = "target5";
    cfg(2'd0, 30'd50, 2'b11, 8'd5);
    for (int i = 0; i < 5; i++) run_pc(32'd200);
    run_pc(32'd200);
    resume_tick();

    phase = "target0";
    cfg(2'd0, 30'd50, 2'b11, 8'd0);
    for (int i = 0; i < 300; i++) run_pc(32'd200);
    tick();

    phase = "clr_hit";
    bus.clr = 1'b1;
    run_pc(32'd200);
    run_pc(32'd200);
    phase = "cfg_hit";
    bus.cfg_we = 1'b1; bus.cfg_sel = 2'd0; bus.cfg_line = 30'd50;
    bus.cfg_mode = 2'b01; bus.cfg_target = 8'd0;
    run_pc(32'd200);
    run_pc(32'd200);

    phase = "async_rst";
    run_pc(32'd9500);
    nreset = 1'b0;
    #1;
    chk("now_pulse", 64'(bus.hit_pulse), 64'd0);
    chk("now_count", 64'(bus.hit_count), 64'd0);
    chk("now_halt",  64'(bus.halt),      64'd0);
    chk("now_hid",   64'(bus.halt_id),   64'd0);
    model_reset();
    @(posedge clk);
    #1;
    nreset = 1'b1;
    tick();
    run_pc(32'd9500);

    phase = "sel_range";
    bus5.cfg_we = 1'b1; bus5.cfg_sel = 3'd0; bus5.cfg_line = 30'd77;
    bus5.cfg_mode = 2'b01; bus5.cfg_target = 8'd0;
    tick5();
    bus5.pc = 32'd308; bus5.pc_valid = 1'b1;
    tick5();
    chk("ch0_count", 64'(bus5.hit_count[7:0]), 64'd1);
    bus5.cfg_we = 1'b1; bus5.cfg_sel = 3'd5; bus5.cfg_line = 30'd77;
    bus5.cfg_mode = 2'b10; bus5.cfg_target = 8'd0;
    tick5();
    chk("after_wr_count", 64'(bus5.hit_count), 64'd1);
    bus5.pc = 32'd308; bus5.pc_valid = 1'b1;
    tick5();
    chk("after_wr_halt",  64'(bus5.halt),      64'd0);
    chk("after_wr_pulse", 64'(bus5.hit_pulse), 64'd1);
    chk("after_wr_cnt2",  64'(bus5.hit_count), 64'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
